// File: rtl/icache_dm_if.sv
// Bus bundle for icache_dm: core-side ibus request/response and
// arbiter-side cbus refill request/response.
interface icache_dm_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;

    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;

    logic        icreq_valid;
    logic        icreq_is_write;
    logic [2:0]  icreq_size;
    logic [63:0] icreq_addr;
    logic [7:0]  icreq_strobe;
    logic [63:0] icreq_data;
    logic [3:0]  icreq_len;
    logic [1:0]  icreq_burst;

    logic        icresp_ready;
    logic        icresp_last;
    logic [63:0] icresp_data;

    modport master (
        output ireq_valid, ireq_addr, icresp_ready, icresp_last, icresp_data,
        input  iresp_addr_ok, iresp_data_ok, iresp_data,
        input  icreq_valid, icreq_is_write, icreq_size, icreq_addr,
        input  icreq_strobe, icreq_data, icreq_len, icreq_burst
    );

    modport slave (
        input  ireq_valid, ireq_addr, icresp_ready, icresp_last, icresp_data,
        output iresp_addr_ok, iresp_data_ok, iresp_data,
        output icreq_valid, icreq_is_write, icreq_size, icreq_addr,
        output icreq_strobe, icreq_data, icreq_len, icreq_burst
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped, read-only, blocking instruction cache. Hits are answered
// combinationally; misses refill a whole line with one INCR burst.
module icache_dm #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned NUM_LINES  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    icache_dm_if.slave  bus
);
    localparam int unsigned WB  = $clog2(LINE_WORDS);
    localparam int unsigned IB  = $clog2(NUM_LINES);
    localparam int unsigned OFS = 3 + WB;
    localparam int unsigned TW  = 64 - OFS - IB;

    localparam logic [2:0] MSIZE8         = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] LINE_LEN       = 4'(LINE_WORDS - 1);

    typedef enum logic {IDLE, FILL} state_e;

    state_e              state_q, state_d;
    logic [WB-1:0]       cnt_q, cnt_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic                flush_pend_q, flush_pend_d;
    logic [63-OFS:0]     line_q, line_d;

    logic [TW-1:0]       tag_q  [NUM_LINES];
    logic [63:0]         data_q [NUM_LINES][LINE_WORDS];

    logic [IB-1:0]       req_idx, fill_idx;
    logic [TW-1:0]       req_tag, fill_tag;
    logic [WB-1:0]       req_word;
    logic [63:0]         rd_word;
    logic                hit, fill_we, fill_done;
    logic                unused_addr_bits;

    assign req_idx  = bus.ireq_addr[OFS+IB-1:OFS];
    assign req_tag  = bus.ireq_addr[63:OFS+IB];
    assign req_word = bus.ireq_addr[OFS-1:3];
    assign fill_idx = line_q[IB-1:0];
    assign fill_tag = line_q[63-OFS:IB];
    assign rd_word  = data_q[req_idx][req_word];
    assign unused_addr_bits = ^bus.ireq_addr[1:0];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q;
        line_d       = line_q;
        fill_we      = 1'b0;
        fill_done    = 1'b0;
        hit          = 1'b0;

        bus.iresp_addr_ok  = 1'b0;
        bus.iresp_data_ok  = 1'b0;
        bus.iresp_data     = '0;
        bus.icreq_valid    = 1'b0;
        bus.icreq_is_write = 1'b0;
        bus.icreq_size     = '0;
        bus.icreq_addr     = '0;
        bus.icreq_strobe   = '0;
        bus.icreq_data     = '0;
        bus.icreq_len      = '0;
        bus.icreq_burst    = '0;

        case (state_q)
            IDLE: begin
                hit = bus.ireq_valid && valid_q[req_idx] &&
                      (tag_q[req_idx] == req_tag) && !flush;
                if (hit) begin
                    bus.iresp_addr_ok = 1'b1;
                    bus.iresp_data_ok = 1'b1;
                    bus.iresp_data    = bus.ireq_addr[2] ? rd_word[63:32] : rd_word[31:0];
                end
                if (flush) begin
                    valid_d = '0;
                end else if (bus.ireq_valid && !hit) begin
                    line_d       = bus.ireq_addr[63:OFS];
                    flush_pend_d = 1'b0;
                    state_d      = FILL;
                end
            end
            FILL: begin
                bus.icreq_valid = 1'b1;
                bus.icreq_size  = MSIZE8;
                bus.icreq_addr  = {line_q, {OFS{1'b0}}};
                bus.icreq_len   = LINE_LEN;
                bus.icreq_burst = AXI_BURST_INCR;
                if (flush) flush_pend_d = 1'b1;
                if (bus.icresp_ready) begin
                    fill_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (bus.icresp_last) begin
                        // A flush seen at any point during the burst also kills the new line.
                        fill_done         = 1'b1;
                        cnt_d             = '0;
                        valid_d[fill_idx] = 1'b1;
                        if (flush || flush_pend_q) valid_d = '0;
                        flush_pend_d      = 1'b0;
                        state_d           = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
            line_q       <= line_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we)   data_q[fill_idx][cnt_q] <= bus.icresp_data;
        if (fill_done) tag_q[fill_idx]         <= fill_tag;
    end
endmodule

// File: tb/tb_icache_dm.sv
// Randomised and directed bench for icache_dm against a line-level
// behavioural cache model and a deterministic memory.
module tb_icache_dm;
    localparam int LW = 4;
    localparam int NL = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    icache_dm_if bus();

    icache_dm #(.LINE_WORDS(LW), .NUM_LINES(NL)) dut (
        .clk   (clk),
        .reset (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: which line address each slot holds, plus the refill in flight.
    bit          mvalid [NL];
    logic [63:0] mline  [NL];
    bit          m_fill = 1'b0;
    bit          m_fp   = 1'b0;
    logic [63:0] m_base = '0;
    int          m_beats = 0;

    logic        obs_dok;
    logic [31:0] obs_data;
    bit          use_pat = 1'b0;
    bit          pat [$];

    function automatic logic [63:0] mem(input logic [63:0] a);
        return {~a[31:0], a[31:0]};
    endfunction

    function automatic logic [63:0] line_of(input logic [63:0] a);
        return a & ~64'(LW * 8 - 1);
    endfunction

    function automatic int idx_of(input logic [63:0] a);
        return int'((a / 64'(LW * 8)) % 64'(NL));
    endfunction

    function automatic logic [63:0] rnd_addr();
        return 64'h8000_0000 + 64'($urandom % 2) * 64'h200
             + 64'($urandom % 4) * 64'h20 + 64'($urandom % 32);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NL; i++) mvalid[i] = 1'b0;
    endtask

    task automatic cycle(input bit v, input logic [63:0] a, input bit fl, input bit rdy);
        bit          r;
        bit          hit;
        logic [63:0] w;
        int          i;
        @(negedge clk);
        bus.ireq_valid = v;
        bus.ireq_addr  = a;
        flush          = fl;
        r = 1'b0;
        if (m_fill) r = use_pat ? ((pat.size() > 0) ? pat.pop_front() : 1'b1) : rdy;
        bus.icresp_ready = r;
        bus.icresp_last  = r && (m_beats == LW - 1);
        bus.icresp_data  = r ? mem(m_base + 64'(m_beats * 8)) : {$urandom, $urandom};
        #1;
        i   = idx_of(a);
        hit = !m_fill && v && !fl && mvalid[i] && (mline[i] == line_of(a));
        w   = mem(a & ~64'h7);
        chk("addr_ok", bus.iresp_addr_ok, hit);
        chk("data_ok", bus.iresp_data_ok, hit);
        if (hit || m_fill) chk("data", bus.iresp_data, hit ? (a[2] ? w[63:32] : w[31:0]) : 0);
        chk("icreq_valid", bus.icreq_valid, m_fill);
        chk("icreq_addr", bus.icreq_addr, m_fill ? m_base : 0);
        chk("icreq_len", bus.icreq_len, m_fill ? LW - 1 : 0);
        chk("icreq_burst", bus.icreq_burst, m_fill ? 1 : 0);
        chk("icreq_size", bus.icreq_size, m_fill ? 3 : 0);
        chk("icreq_wr_strb", {bus.icreq_is_write, bus.icreq_strobe}, 0);
        chk("icreq_wdata", bus.icreq_data, 0);
        obs_dok  = bus.iresp_data_ok;
        obs_data = bus.iresp_data;
        @(posedge clk);
        if (!m_fill) begin
            if (fl) model_clear();
            else if (v && !hit) begin
                m_fill = 1'b1; m_base = line_of(a); m_beats = 0; m_fp = 1'b0;
            end
        end else begin
            if (fl) m_fp = 1'b1;
            if (r) begin
                m_beats++;
                if (m_beats == LW) begin
                    mvalid[idx_of(m_base)] = 1'b1;
                    mline[idx_of(m_base)]  = m_base;
                    m_fill = 1'b0;
                    if (m_fp) model_clear();
                end
            end
        end
    endtask

    task automatic fetch(input logic [63:0] a, output int lat);
        lat = 0;
        forever begin
            cycle(1'b1, a, 1'b0, 1'b1);
            if (obs_dok) break;
            lat++;
            if (lat > 60) begin
                vectors++;
                miscompares++;
                $display("FAIL fetch_timeout: addr %h no data_ok after %0d cycles", a, lat);
                break;
            end
        end
    endtask

    task automatic async_reset_now();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_icreq_valid", bus.icreq_valid, 0);
        chk("rst_iresp", {bus.iresp_addr_ok, bus.iresp_data_ok, bus.iresp_data}, 0);
        model_clear();
        m_fill = 1'b0; m_fp = 1'b0; m_beats = 0;
        bus.ireq_valid = 1'b0; bus.icresp_ready = 1'b0; bus.icresp_last = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int          lat;
        logic [63:0] cur;
        bit          v;

        bus.ireq_valid = 1'b0; bus.ireq_addr = '0;
        bus.icresp_ready = 1'b0; bus.icresp_last = 1'b0; bus.icresp_data = '0;
        model_clear();
        #12;
        chk("reset_icreq_valid", bus.icreq_valid, 0);
        chk("reset_data_ok", bus.iresp_data_ok, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold miss, then same-line hits
        fetch(64'h8000_0000, lat);
        chk("t1_latency", lat, 5);
        chk("t1_data", obs_data, 32'h8000_0000);
        fetch(64'h8000_0004, lat);
        chk("t2_lat_a", lat, 0);
        chk("t2_data_a", obs_data, 32'h7FFF_FFFF);
        fetch(64'h8000_0008, lat);
        chk("t2_data_b", obs_data, 32'h8000_0008);
        fetch(64'h8000_001C, lat);
        chk("t2_lat_c", lat, 0);
        chk("t2_data_c", obs_data, 32'h7FFF_FFE7);

        // Conflict eviction
        fetch(64'h8000_0200, lat);
        chk("t3_lat_a", lat, 5);
        chk("t3_data_a", obs_data, 32'h8000_0200);
        fetch(64'h8000_0000, lat);
        chk("t3_lat_b", lat, 5);

        // Flush in IDLE, then flush during beat 2
        cycle(1'b0, 64'h0, 1'b1, 1'b0);
        fetch(64'h8000_0000, lat);
        chk("t4_lat_a", lat, 5);
        cycle(1'b1, 64'h8000_0040, 1'b0, 1'b1);
        cycle(1'b1, 64'h8000_0040, 1'b0, 1'b1);
        cycle(1'b1, 64'h8000_0040, 1'b1, 1'b1);
        cycle(1'b1, 64'h8000_0040, 1'b0, 1'b1);
        cycle(1'b1, 64'h8000_0040, 1'b0, 1'b1);
        fetch(64'h8000_0040, lat);
        chk("t4_lat_b", lat, 5);

        // Reset after beat 2 of a fill
        cycle(1'b1, 64'h8000_0060, 1'b0, 1'b1);
        cycle(1'b1, 64'h8000_0060, 1'b0, 1'b1);
        cycle(1'b1, 64'h8000_0060, 1'b0, 1'b1);
        async_reset_now();
        fetch(64'h8000_0064, lat);
        chk("t5_lat", lat, 5);
        chk("t5_data", obs_data, 32'h7FFF_FF9F);

        // Backpressure 1,0,0,1,1,0,1
        use_pat = 1'b1;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        fetch(64'h8000_0080, lat);
        chk("t6_lat", lat, 8);
        use_pat = 1'b0;
        fetch(64'h8000_0098, lat);
        chk("t6_lat_hit", lat, 0);
        chk("t6_data", obs_data, 32'h8000_0098);

        // Random traffic
        cur = rnd_addr();
        repeat (3000) begin
            if (($urandom % 500) == 0) async_reset_now();
            v = ($urandom % 10) < 8;
            if (m_fill && ($urandom % 8) == 0) cur = rnd_addr();
            cycle(v, cur, ($urandom % 40) == 0, ($urandom % 10) < 6);
            if (obs_dok || !v) cur = rnd_addr();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
